voq_buffer: RTL and testbench
=============================

Name: voq_buffer

Overview:
- Ingress-side virtual output queue store for one switch input port.
- Holds packet descriptors in four per-egress FIFOs (one VOQ per output port). Exports a per-VOQ empty vector to the VOQ picker.
- Accepts a dequeue of the VOQ index the picker selects and returns that VOQ's head descriptor.
- Sits between the ingress packet writer (enqueue side) and the round-robin VOQ picker / crossbar scheduler (dequeue side).

Parameters:
- DESC_WIDTH, 8: width of a packet descriptor (packet buffer address plus length tag).
- VOQ_DEPTH, 8: entries per VOQ; power of two, at least 2.
- NUM_VOQ is not a parameter; it is fixed at 4 (2-bit VOQ index).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- enq_valid  input  1  enqueue request this cycle.
- enq_voq  input  2  destination VOQ of the enqueued descriptor.
- enq_desc  input  DESC_WIDTH  descriptor to enqueue.
- enq_drop  output  1  registered pulse: the previous cycle's enqueue was rejected because the VOQ was full.
- deq_req  input  1  dequeue request this cycle.
- deq_voq  input  2  VOQ to dequeue; driven from the picker's selected index.
- deq_valid  output  1  registered: deq_desc holds a dequeued descriptor.
- deq_desc  output  DESC_WIDTH  head descriptor of the dequeued VOQ.
- voq_empty  output  4  bit i high when VOQ i holds 0 entries; feeds the picker.
- voq_full  output  4  bit i high when VOQ i holds VOQ_DEPTH entries.

Behaviour:
- Reset values:
  - voq_empty = 4'b1111, voq_full = 4'b0000.
  - deq_valid = 0, deq_desc = 0, enq_drop = 0.
  - All read/write pointers and counts = 0.
  - Storage contents are don't-care.
- Reset mid-operation discards all queued entries.
  - Any enqueue or dequeue presented in the reset cycle is ignored.
  - No deq_valid or enq_drop pulse results from it.
- Per VOQ state:
  - write pointer and read pointer, each log2(VOQ_DEPTH) bits, wrapping modulo VOQ_DEPTH.
  - count, log2(VOQ_DEPTH)+1 bits.
- Storage: one array of 4*VOQ_DEPTH entries, addressed {voq_index, pointer}.
- Enqueue, evaluated at the clock edge:
  - If enq_valid and voq_full[enq_voq] = 0: write enq_desc at {enq_voq, wptr}, increment wptr, increment count.
  - If enq_valid and voq_full[enq_voq] = 1: no state change; enq_drop = 1 next cycle.
- Dequeue, evaluated at the clock edge:
  - If deq_req and voq_empty[deq_voq] = 0: deq_desc <= entry {deq_voq, rptr}, deq_valid <= 1, increment rptr, decrement count.
  - If deq_req on an empty VOQ: deq_valid <= 0, no state change. This is legal and not an error.
- Dequeue latency is 1 cycle: request at edge N, descriptor visible after edge N, held until the next edge.
- deq_valid is a single-cycle pulse per accepted dequeue. Back-to-back dequeues are allowed every cycle.
- Full/empty decisions use the registered voq_full and voq_empty values from before the edge.
- Simultaneous enqueue and dequeue, same VOQ:
  - VOQ empty: the enqueue is accepted, the dequeue is ignored (no bypass). Count becomes 1 and deq_valid = 0.
  - VOQ full: the enqueue is dropped even though the dequeue frees a slot. The dequeue proceeds and count becomes VOQ_DEPTH-1.
  - Otherwise: both proceed and count is unchanged.
- Simultaneous enqueue and dequeue on different VOQs: fully independent.
- voq_empty and voq_full are registered. They reflect the counts after the most recent edge, so the picker sees a new entry one cycle after its enqueue edge.
- FIFO order is strict per VOQ.
- Pointer wrap from VOQ_DEPTH-1 to 0 must be seamless.

Decomposition:
- Shared package (switch_pkg):
  - constants NUM_VOQ = 4 and VOQ_IDX_W = 2.
  - typedef voq_idx_t (logic [1:0]).
  - typedef voq_vec_t (logic [3:0]), shared with the picker and the scheduler.
- Sub-module voq_ptr_ctrl, instantiated 4 times:
  - holds wptr, rptr and count for one VOQ.
  - inputs: push, pop.
  - outputs: wptr, rptr, empty, full.
- The top-level voq_buffer owns the storage array, enqueue/dequeue decode and the output registers.

Test Plan:
- Reset, then idle → voq_empty=1111, voq_full=0000, deq_valid=0. Enqueue desc 8'h11 to VOQ 2 → voq_empty=1011 one cycle later.
- Enqueue 8'hA0..8'hA7 to VOQ 1 (8 entries) → voq_full=0010. Ninth enqueue 8'hA8 → enq_drop=1. Eight dequeues of VOQ 1 return A0..A7 in order with deq_valid each cycle, then voq_empty[1]=1.
- Fill VOQ 3 to 8 entries, drain 5, enqueue 5 more → wrap exercised; remaining 8 dequeues return the correct FIFO order.
- VOQ 0 empty, same-cycle enqueue 8'h5A and dequeue of VOQ 0 → deq_valid=0, count=1. The next-cycle dequeue returns 8'h5A.
- VOQ 2 full, same-cycle enqueue and dequeue of VOQ 2 → head returned, enq_drop=1, count=7, voq_full[2]=0.
- Enqueue 3 entries into VOQ 0, assert reset for one cycle with deq_req=1 → deq_valid=0, voq_empty=1111. A dequeue of VOQ 0 after reset gives deq_valid=0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: VOQ count, VOQ index and per-VOQ vector types.
package switch_pkg;

  localparam int NUM_VOQ   = 4;
  localparam int VOQ_IDX_W = 2;

  typedef logic [VOQ_IDX_W-1:0] voq_idx_t;
  typedef logic [NUM_VOQ-1:0]   voq_vec_t;

endpackage

// File: rtl/voq_ptr_ctrl.sv
// Pointer and occupancy tracking for a single VOQ.
// push/pop arrive already qualified against full/empty by the caller.
module voq_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic             empty,
  output logic             full
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wptr_d, wptr_q;
  logic [PTR_W-1:0] rptr_d, rptr_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             empty_d, empty_q;
  logic             full_d, full_q;

  // Next pointers/count; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  // State registers; flags are registered so they track the post-edge count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/voq_buffer.sv
// Ingress virtual output queue store: four per-egress descriptor FIFOs
// sharing one storage array addressed {voq, pointer}.
module voq_buffer
  import switch_pkg::*;
#(
  parameter int DESC_WIDTH = 8,
  parameter int VOQ_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_valid,
  input  voq_idx_t              enq_voq,
  input  logic [DESC_WIDTH-1:0] enq_desc,
  output logic                  enq_drop,
  input  logic                  deq_req,
  input  voq_idx_t              deq_voq,
  output logic                  deq_valid,
  output logic [DESC_WIDTH-1:0] deq_desc,
  output voq_vec_t              voq_empty,
  output voq_vec_t              voq_full
);

  localparam int PTR_W  = $clog2(VOQ_DEPTH);
  localparam int ADDR_W = VOQ_IDX_W + PTR_W;
  localparam int MEM_N  = NUM_VOQ * VOQ_DEPTH;

  logic [DESC_WIDTH-1:0] mem_q [MEM_N];
  logic [PTR_W-1:0]      wptr [NUM_VOQ];
  logic [PTR_W-1:0]      rptr [NUM_VOQ];

  voq_vec_t              push, pop;
  logic                  enq_ok, deq_ok;
  logic [ADDR_W-1:0]     wr_addr, rd_addr;

  logic                  deq_valid_d, deq_valid_q;
  logic [DESC_WIDTH-1:0] deq_desc_d, deq_desc_q;
  logic                  enq_drop_d, enq_drop_q;

  // Accept decisions use the registered flags, so an empty VOQ never
  // bypasses a same-cycle enqueue and a full VOQ drops even while draining.
  always_comb begin
    enq_ok  = enq_valid && !voq_full[enq_voq];
    deq_ok  = deq_req && !voq_empty[deq_voq];
    push    = '0;
    pop     = '0;
    if (enq_ok) push[enq_voq] = 1'b1;
    if (deq_ok) pop[deq_voq]  = 1'b1;
    wr_addr = {enq_voq, wptr[enq_voq]};
    rd_addr = {deq_voq, rptr[deq_voq]};
  end

  for (genvar i = 0; i < NUM_VOQ; i++) begin : g_voq
    voq_ptr_ctrl #(
      .DEPTH (VOQ_DEPTH)
    ) u_ptr (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wptr  (wptr[i]),
      .rptr  (rptr[i]),
      .empty (voq_empty[i]),
      .full  (voq_full[i])
    );
  end

  // Descriptor storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (enq_ok && !reset) mem_q[wr_addr] <= enq_desc;
  end

  // Output next-state: deq_desc holds its last value when nothing is popped.
  always_comb begin
    deq_valid_d = deq_ok;
    deq_desc_d  = deq_desc_q;
    if (deq_ok) deq_desc_d = mem_q[rd_addr];
    enq_drop_d  = enq_valid && voq_full[enq_voq];
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      deq_valid_q <= 1'b0;
      deq_desc_q  <= '0;
      enq_drop_q  <= 1'b0;
    end else begin
      deq_valid_q <= deq_valid_d;
      deq_desc_q  <= deq_desc_d;
      enq_drop_q  <= enq_drop_d;
    end
  end

  assign deq_valid = deq_valid_q;
  assign deq_desc  = deq_desc_q;
  assign enq_drop  = enq_drop_q;

endmodule

// File: tb/tb_voq_buffer.sv
// Directed bench for voq_buffer with hand-computed expectations.
module tb_voq_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_valid;
  logic [1:0] enq_voq;
  logic [7:0] enq_desc;
  logic       enq_drop;
  logic       deq_req;
  logic [1:0] deq_voq;
  logic       deq_valid;
  logic [7:0] deq_desc;
  logic [3:0] voq_empty;
  logic [3:0] voq_full;

  int n_checks = 0;
  int n_errors = 0;

  voq_buffer #(.DESC_WIDTH(8), .VOQ_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_voq   (enq_voq),
    .enq_desc  (enq_desc),
    .enq_drop  (enq_drop),
    .deq_req   (deq_req),
    .deq_voq   (deq_voq),
    .deq_valid (deq_valid),
    .deq_desc  (deq_desc),
    .voq_empty (voq_empty),
    .voq_full  (voq_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request pattern; outputs sampled 1 ns after the edge.
  task automatic cyc(input logic ev, input logic [1:0] ev_voq, input logic [7:0] d,
                     input logic dr, input logic [1:0] dv);
    enq_valid = ev;
    enq_voq   = ev_voq;
    enq_desc  = d;
    deq_req   = dr;
    deq_voq   = dv;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_req   = 1'b0;
  endtask

  task automatic enq(input logic [1:0] v, input logic [7:0] d);
    cyc(1'b1, v, d, 1'b0, 2'd0);
  endtask

  task automatic deq(input logic [1:0] v);
    cyc(1'b0, 2'd0, 8'h00, 1'b1, v);
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enq_valid = 1'b0;
    enq_voq   = 2'd0;
    enq_desc  = 8'h00;
    deq_req   = 1'b0;
    deq_voq   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    idle();
    chk("rst_empty", voq_empty, 4'b1111);
    chk("rst_full", voq_full, 4'b0000);
    chk("rst_deq_valid", deq_valid, 1'b0);
    chk("rst_deq_desc", deq_desc, 8'h00);
    chk("rst_enq_drop", enq_drop, 1'b0);

    // Single enqueue becomes visible on the flags after its edge
    enq(2'd2, 8'h11);
    chk("enq_v2_empty", voq_empty, 4'b1011);

    // Fill VOQ 1, overflow, then drain in order
    for (int i = 0; i < 8; i++) enq(2'd1, 8'hA0 + 8'(i));
    chk("v1_full", voq_full, 4'b0010);
    chk("v1_not_empty", voq_empty, 4'b1001);
    enq(2'd1, 8'hA8);
    chk("v1_drop", enq_drop, 1'b1);
    chk("v1_still_full", voq_full, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      deq(2'd1);
      if (i == 0) chk("v1_drop_clear", enq_drop, 1'b0);
      chk("v1_deq_valid", deq_valid, 1'b1);
      chk("v1_deq_desc", deq_desc, 8'hA0 + 8'(i));
    end
    chk("v1_drained", voq_empty, 4'b1011);
    chk("v1_full_clear", voq_full, 4'b0000);
    idle();
    chk("deq_valid_pulse", deq_valid, 1'b0);
    chk("deq_desc_hold", deq_desc, 8'hA7);

    // Pointer wrap on VOQ 3
    for (int i = 0; i < 8; i++) enq(2'd3, 8'hB0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      deq(2'd3);
      chk("v3_deq_a", deq_desc, 8'hB0 + 8'(i));
    end
    for (int i = 0; i < 5; i++) enq(2'd3, 8'hB8 + 8'(i));
    chk("v3_full_after_wrap", voq_full, 4'b1000);
    for (int i = 0; i < 8; i++) begin
      deq(2'd3);
      chk("v3_wrap_valid", deq_valid, 1'b1);
      chk("v3_wrap_desc", deq_desc, 8'hB5 + 8'(i));
    end
    chk("v3_drained", voq_empty[3], 1'b1);

    // Empty VOQ 0: enqueue accepted, same-cycle dequeue ignored
    cyc(1'b1, 2'd0, 8'h5A, 1'b1, 2'd0);
    chk("v0_nobypass_valid", deq_valid, 1'b0);
    chk("v0_count1", voq_empty[0], 1'b0);
    deq(2'd0);
    chk("v0_deq_valid", deq_valid, 1'b1);
    chk("v0_deq_desc", deq_desc, 8'h5A);
    chk("v0_empty_again", voq_empty[0], 1'b1);
    deq(2'd0);
    chk("v0_empty_deq", deq_valid, 1'b0);

    // Full VOQ 2 (holds 8'h11 already): enqueue drops while dequeue proceeds
    for (int i = 1; i < 8; i++) enq(2'd2, 8'hC0 + 8'(i));
    chk("v2_full", voq_full[2], 1'b1);
    cyc(1'b1, 2'd2, 8'hCC, 1'b1, 2'd2);
    chk("v2_sim_valid", deq_valid, 1'b1);
    chk("v2_sim_desc", deq_desc, 8'h11);
    chk("v2_sim_drop", enq_drop, 1'b1);
    chk("v2_sim_full", voq_full[2], 1'b0);
    for (int i = 1; i < 8; i++) begin
      deq(2'd2);
      chk("v2_drain_desc", deq_desc, 8'hC0 + 8'(i));
    end
    chk("v2_seven_left", voq_empty[2], 1'b1);

    // Independent and same-VOQ non-boundary concurrency
    enq(2'd1, 8'hE0);
    enq(2'd3, 8'hE1);
    cyc(1'b1, 2'd1, 8'hE2, 1'b1, 2'd3);
    chk("diff_deq_desc", deq_desc, 8'hE1);
    chk("diff_empty", voq_empty, 4'b1101);
    cyc(1'b1, 2'd1, 8'hE3, 1'b1, 2'd1);
    chk("same_deq_desc", deq_desc, 8'hE0);
    chk("same_drop", enq_drop, 1'b0);
    deq(2'd1);
    chk("same_next_a", deq_desc, 8'hE2);
    deq(2'd1);
    chk("same_next_b", deq_desc, 8'hE3);
    chk("same_empty", voq_empty, 4'b1111);

    // Reset mid-operation with a pending dequeue and enqueue
    for (int i = 0; i < 3; i++) enq(2'd0, 8'hD0 + 8'(i));
    reset     = 1'b1;
    enq_valid = 1'b1;
    enq_voq   = 2'd1;
    enq_desc  = 8'hF0;
    deq_req   = 1'b1;
    deq_voq   = 2'd0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    enq_valid = 1'b0;
    deq_req   = 1'b0;
    chk("mrst_deq_valid", deq_valid, 1'b0);
    chk("mrst_enq_drop", enq_drop, 1'b0);
    chk("mrst_empty", voq_empty, 4'b1111);
    chk("mrst_full", voq_full, 4'b0000);
    chk("mrst_desc", deq_desc, 8'h00);
    deq(2'd0);
    chk("mrst_deq_after", deq_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
